// File: rtl/sipo_pkg.sv
// Shared constants and types for the serial-in/parallel-out deserialiser slice.
// Word width, FIFO depth, bit-order enum and the bit-counter width helper.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } bit_order_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sipo_sync_fifo.sv
// Show-ahead synchronous FIFO for assembled words.
// It drops a push when full unless a pop frees a slot in the same cycle, and ignores a pop while empty.
module sipo_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (fill == '0);
  assign full    = (fill == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; the pointers define validity and rdata is gated while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: non-blocking assignments keep every register reading the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      fill <= fill + 1'b1;
      else if (do_pop && !do_push) fill <= fill - 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deser_fifo.sv
// Serial-to-parallel deserialiser: shifts mosi on sck, then pushes each completed word into a show-ahead FIFO.
// It also produces a one-cycle completion pulse and a sticky overflow flag for dropped words.
module sipo_deser_fifo
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         sck,
  input  logic                         ss,
  input  logic                         mosi,
  input  logic                         ready,
  input  logic                         done,
  input  logic                         word_ack,
  input  logic                         clear_ovf,
  output logic                         pulse,
  output logic                         word_valid,
  output logic [WIDTH-1:0]             word_data,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam bit_order_e ORDER = MSB_FIRST ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] next_word;
  logic [CW-1:0]    bit_cnt;
  logic             shift_en;
  logic             complete;
  logic             fifo_empty;
  logic             dropped;

  assign shift_en = ready && !done;
  assign complete = shift_en && (bit_cnt == LAST_BIT);

  // NOTE: both branches assign next_word, so no latch is inferred.
  always_comb begin
    if (ORDER == ORDER_MSB_FIRST) next_word = {shift_reg[WIDTH-2:0], mosi};
    else                          next_word = {mosi, shift_reg[WIDTH-1:1]};
  end

  always_ff @(posedge sck) begin
    if (ss) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      pulse     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      pulse <= complete;
      if (shift_en) begin
        shift_reg <= next_word;
        bit_cnt   <= complete ? '0 : bit_cnt + 1'b1;
      end
      // A drop beats a simultaneous clear so no lost word goes unreported.
      if (dropped)        overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  sipo_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sck),
    .rst     (ss),
    .push    (complete),
    .pop     (word_ack),
    .wdata   (next_word),
    .rdata   (word_data),
    .empty   (fifo_empty),
    .fill    (fill),
    .dropped (dropped)
  );

  assign word_valid = !fifo_empty;

endmodule

// File: tb/tb_sipo_deser_fifo.sv
// Self-checking bench for sipo_deser_fifo, with one default DUT plus LSB-first and 8-bit variants.
// Expected words enter a scoreboard queue when they are sent and are compared as the consumer pops them.
module tb_sipo_deser_fifo;

  logic sck = 1'b0;
  logic ss = 1'b1;
  logic mosi = 1'b0;
  logic ready = 1'b0;
  logic done = 1'b0;
  logic word_ack = 1'b0;
  logic clear_ovf = 1'b0;
  logic ready_l = 1'b0;
  logic ready_8 = 1'b0;

  logic       pulse, word_valid, overflow;
  logic [3:0] word_data;
  logic [2:0] fill;
  logic       pulse_l, valid_l, ovf_l;
  logic [3:0] data_l;
  logic [2:0] fill_l;
  logic       pulse_8, valid_8, ovf_8;
  logic [7:0] data_8;
  logic [2:0] fill_8;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  logic [3:0] exp_q [$];

  sipo_deser_fifo #(.WIDTH(4), .DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .sck(sck), .ss(ss), .mosi(mosi), .ready(ready), .done(done),
    .word_ack(word_ack), .clear_ovf(clear_ovf), .pulse(pulse),
    .word_valid(word_valid), .word_data(word_data), .fill(fill), .overflow(overflow)
  );

  sipo_deser_fifo #(.WIDTH(4), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .sck(sck), .ss(ss), .mosi(mosi), .ready(ready_l), .done(done),
    .word_ack(1'b0), .clear_ovf(1'b0), .pulse(pulse_l),
    .word_valid(valid_l), .word_data(data_l), .fill(fill_l), .overflow(ovf_l)
  );

  sipo_deser_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut_w8 (
    .sck(sck), .ss(ss), .mosi(mosi), .ready(ready_8), .done(done),
    .word_ack(1'b0), .clear_ovf(1'b0), .pulse(pulse_8),
    .word_valid(valid_8), .word_data(data_8), .fill(fill_8), .overflow(ovf_8)
  );

  always #5 sck = ~sck;

  // Count main pulses mid-cycle, away from the active edge.
  always @(negedge sck) if (pulse === 1'b1) pulse_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  // Sends w MSB-first on the main DUT; optionally acks the head or clears overflow on the last bit.
  task automatic send_word(input logic [3:0] w, input bit keep, input bit ack_last, input bit clr_last);
    for (int i = 3; i >= 0; i--) begin
      mosi = w[i];
      if (i == 0) begin
        if (ack_last) begin
          if (exp_q.size() > 0) begin
            check("head_before_ack", 32'(word_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
          end
          word_ack = 1'b1;
        end
        clear_ovf = clr_last;
      end
      tick();
      word_ack  = 1'b0;
      clear_ovf = 1'b0;
      if (i == 0) check("pulse_on_complete", 32'(pulse), 32'd1);
      else        check("pulse_mid_word", 32'(pulse), 32'd0);
    end
    if (keep) exp_q.push_back(w);
  endtask

  task automatic pop_head(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty_valid"}, 32'(word_valid), 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_valid"}, 32'(word_valid), 32'd1);
    check({tag, "_data"}, 32'(word_data), 32'(e));
    word_ack = 1'b1;
    tick();
    word_ack = 1'b0;
  endtask

  initial begin
    int base;
    logic [7:0] w8;

    // Reset state
    tick();
    tick();
    check("rst_pulse", 32'(pulse), 32'd0);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_data", 32'(word_data), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_fill_w8", 32'(fill_8), 32'd0);
    ss = 1'b0;

    // Stream 1,0,1,1 into the MSB-first and LSB-first DUTs together
    ready = 1'b1;
    ready_l = 1'b1;
    send_word(4'b1011, 1'b1, 1'b0, 1'b0);
    ready = 1'b0;
    ready_l = 1'b0;
    check("t1_fill", 32'(fill), 32'd1);
    check("t1_valid", 32'(word_valid), 32'd1);
    check("t1_head", 32'(word_data), 32'(exp_q[0]));
    check("t2_lsb_pulse", 32'(pulse_l), 32'd1);
    check("t2_lsb_data", 32'(data_l), 32'b1101);
    check("t2_lsb_fill", 32'(fill_l), 32'd1);
    tick();
    check("t1_pulse_frozen", 32'(pulse), 32'd0);
    check("t1_fill_hold", 32'(fill), 32'd1);
    pop_head("t1_pop");
    check("t1_fill_after_pop", 32'(fill), 32'd0);
    check("t1_data_empty", 32'(word_data), 32'd0);

    // 8-bit variant receives 0xA5 MSB-first
    w8 = 8'hA5;
    ready_8 = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      mosi = w8[i];
      tick();
    end
    ready_8 = 1'b0;
    check("t2_w8_pulse", 32'(pulse_8), 32'd1);
    check("t2_w8_valid", 32'(valid_8), 32'd1);
    check("t2_w8_data", 32'(data_8), 32'hA5);

    // A freeze in the middle of a word keeps the partial word
    base = pulse_cnt;
    exp_q.push_back(4'b1011);
    ready = 1'b1;
    mosi = 1'b1; tick();
    mosi = 1'b0; tick();
    done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom_range(0, 1));
      tick();
      check("t3_pulse_frozen", 32'(pulse), 32'd0);
    end
    done = 1'b0;
    mosi = 1'b1; tick();
    mosi = 1'b1; tick();
    check("t3_pulse", 32'(pulse), 32'd1);
    ready = 1'b0;
    tick();
    check("t3_pulse_count", 32'(pulse_cnt - base), 32'd1);
    pop_head("t3_pop");

    // A reset in the middle of a word discards the partial bits
    ready = 1'b1;
    mosi = 1'b1; tick();
    tick();
    ss = 1'b1; tick();
    ss = 1'b0;
    check("t3_rst_fill", 32'(fill), 32'd0);
    check("t3_rst_pulse", 32'(pulse), 32'd0);
    send_word(4'b0110, 1'b1, 1'b0, 1'b0);
    ready = 1'b0;
    pop_head("t3_clean_pop");

    // Overflow: five words with no consumer
    base = pulse_cnt;
    ready = 1'b1;
    send_word(4'h1, 1'b1, 1'b0, 1'b0);
    send_word(4'h2, 1'b1, 1'b0, 1'b0);
    send_word(4'h3, 1'b1, 1'b0, 1'b0);
    send_word(4'h4, 1'b1, 1'b0, 1'b0);
    check("t4_full_fill", 32'(fill), 32'd4);
    check("t4_no_ovf_yet", 32'(overflow), 32'd0);
    send_word(4'hF, 1'b0, 1'b0, 1'b0);
    ready = 1'b0;
    check("t4_drop_fill", 32'(fill), 32'd4);
    check("t4_ovf_set", 32'(overflow), 32'd1);
    tick();
    check("t4_pulse_count", 32'(pulse_cnt - base), 32'd5);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    check("t4_ovf_cleared", 32'(overflow), 32'd0);
    ready = 1'b1;
    send_word(4'hE, 1'b0, 1'b0, 1'b1);
    ready = 1'b0;
    check("t4_set_wins", 32'(overflow), 32'd1);
    check("t4_head_kept", 32'(word_data), 32'(exp_q[0]));
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    check("t4_ovf_cleared2", 32'(overflow), 32'd0);

    // Full FIFO: completion coincides with ack, across the pointer wrap
    ready = 1'b1;
    send_word(4'h5, 1'b1, 1'b1, 1'b0);
    send_word(4'h6, 1'b1, 1'b1, 1'b0);
    ready = 1'b0;
    check("t5_fill", 32'(fill), 32'd4);
    check("t5_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) pop_head("t5_drain");
    check("t5_empty_fill", 32'(fill), 32'd0);
    check("t5_empty_valid", 32'(word_valid), 32'd0);
    check("t5_empty_data", 32'(word_data), 32'd0);

    // Ack while empty is ignored
    word_ack = 1'b1; tick(); word_ack = 1'b0;
    check("t6_underflow_fill", 32'(fill), 32'd0);
    check("t6_underflow_valid", 32'(word_valid), 32'd0);

    // Push and ack together while empty: the push wins
    ready = 1'b1;
    send_word(4'h9, 1'b1, 1'b1, 1'b0);
    ready = 1'b0;
    check("t6_push_pop_empty_fill", 32'(fill), 32'd1);
    pop_head("t6_pop");

    // A reset with three words buffered empties the FIFO
    ready = 1'b1;
    send_word(4'hA, 1'b1, 1'b0, 1'b0);
    send_word(4'hB, 1'b1, 1'b0, 1'b0);
    send_word(4'hC, 1'b1, 1'b0, 1'b0);
    ready = 1'b0;
    check("t6_fill3", 32'(fill), 32'd3);
    ss = 1'b1; tick(); ss = 1'b0;
    exp_q.delete();
    check("t6_rst_fill", 32'(fill), 32'd0);
    check("t6_rst_valid", 32'(word_valid), 32'd0);
    check("t6_rst_pulse", 32'(pulse), 32'd0);
    check("t6_rst_data", 32'(word_data), 32'd0);

    // Normal operation after the reset
    ready = 1'b1;
    send_word(4'h3, 1'b1, 1'b0, 1'b0);
    ready = 1'b0;
    pop_head("t6_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
